// File: rtl/alu_pkg.sv
// Shared types and the combinational ALU evaluation function for the execute unit.
// The evaluation function works on up to 64-bit operands; the caller states its datapath width.
package alu_pkg;

    localparam int ALU_MAX_W = 64;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } exec_state_e;

    // Operands are treated as width-bit values held in the low bits; the result is masked back to width bits.
    // Opcodes without a combinational meaning (MUL and 11..15) yield zero.
    function automatic logic [ALU_MAX_W-1:0] alu_eval(input logic [3:0] op,
                                                      input logic [ALU_MAX_W-1:0] a,
                                                      input logic [ALU_MAX_W-1:0] b,
                                                      input int width);
        logic [ALU_MAX_W-1:0] mask;
        logic [ALU_MAX_W-1:0] signBit;
        logic [ALU_MAX_W-1:0] ua;
        logic [ALU_MAX_W-1:0] ub;
        logic [ALU_MAX_W-1:0] sa;
        logic [ALU_MAX_W-1:0] sb;
        logic [ALU_MAX_W-1:0] sh;
        logic [ALU_MAX_W-1:0] res;
        mask    = (64'd1 << width) - 64'd1;
        signBit = mask & ~(mask >> 1);
        ua      = a & mask;
        ub      = b & mask;
        sa      = ((ua & signBit) != '0) ? (ua | ~mask) : ua;
        sb      = ((ub & signBit) != '0) ? (ub | ~mask) : ub;
        sh      = b & 64'(width - 1);
        res     = '0;
        case (op)
            OP_ADD:  res = ua + ub;
            OP_SUB:  res = ua - ub;
            OP_AND:  res = ua & ub;
            OP_OR:   res = ua | ub;
            OP_XOR:  res = ua ^ ub;
            OP_SLL:  res = ua << sh;
            OP_SRL:  res = ua >> sh;
            OP_SRA:  res = 64'($signed(sa) >>> sh);
            OP_SLT:  res = {63'd0, ($signed(sa) < $signed(sb))};
            OP_SLTU: res = {63'd0, (ua < ub)};
            default: res = '0;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: pulse i_start with the operands, o_done is high
// in the W-th busy cycle, during which o_product holds the low W bits of the product.
module mul_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_done,
    output logic [W-1:0] o_product
);

    localparam int CW = $clog2(W);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  w_partial;

    assign w_partial = r_b[0] ? r_a : '0;
    assign o_product = r_acc + w_partial;
    assign o_done    = r_busy && (r_cnt == CW'(W - 1));

    // One multiplier bit per cycle: add the shifted multiplicand when the current multiplier bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_a    <= i_a;
            r_b    <= i_b;
            r_acc  <= '0;
        end else if (r_busy) begin
            r_acc <= o_product;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Execute unit: register file, WB->EX forwarding, ALU and a single write-back register.
// Optional iterative multiplier enabled by defining ALU_MUL_EN; without it opcode 10 returns 0.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               alu_src,
    input  logic [3:0]         alu_ctrl,
    input  logic               reg_write,
    input  logic [A_WIDTH-1:0] rs1,
    input  logic [A_WIDTH-1:0] rs2,
    input  logic [A_WIDTH-1:0] rd,
    input  logic [D_WIDTH-1:0] imm_op,
    output logic               out_valid,
    output logic [D_WIDTH-1:0] result,
    output logic               eq,
    output logic [D_WIDTH-1:0] a0
);

    localparam int NREGS = 2 ** A_WIDTH;

    logic [D_WIDTH-1:0] r_regs [NREGS];

    logic               r_wbValid;
    logic               r_wbWe;
    logic [A_WIDTH-1:0] r_wbRd;
    logic [D_WIDTH-1:0] r_wbResult;
    logic               r_wbEq;

    logic               w_accept;
    logic [D_WIDTH-1:0] w_op1;
    logic [D_WIDTH-1:0] w_op2;
    logic [D_WIDTH-1:0] w_rf2;
    logic [D_WIDTH-1:0] w_aluResult;
    logic               w_eq;

    logic               w_load;
    logic               w_loadWe;
    logic [A_WIDTH-1:0] w_loadRd;
    logic [D_WIDTH-1:0] w_loadResult;
    logic               w_loadEq;

    assign w_accept  = in_valid & in_ready;
    assign out_valid = r_wbValid;
    assign result    = r_wbResult;
    assign eq        = r_wbEq;
    assign a0        = r_regs[10];

    // Register read with x0 forced to zero, then bypass from the write-back stage when it targets the same register.
    always_comb begin
        w_op1 = (rs1 == '0) ? '0 : r_regs[rs1];
        w_rf2 = (rs2 == '0) ? '0 : r_regs[rs2];
        if (r_wbValid && r_wbWe && (r_wbRd != '0) && (r_wbRd == rs1)) begin
            w_op1 = r_wbResult;
        end
        if (r_wbValid && r_wbWe && (r_wbRd != '0) && (r_wbRd == rs2)) begin
            w_rf2 = r_wbResult;
        end
        w_op2 = alu_src ? imm_op : w_rf2;
    end

    assign w_aluResult = D_WIDTH'(alu_eval(alu_ctrl, 64'(w_op1), 64'(w_op2), D_WIDTH));
    assign w_eq        = (w_op1 == w_op2);

`ifdef ALU_MUL_EN
    exec_state_e        r_state;
    exec_state_e        w_nextState;
    logic               w_mulStart;
    logic               w_mulDone;
    logic [D_WIDTH-1:0] w_product;
    logic               r_mulWe;
    logic [A_WIDTH-1:0] r_mulRd;
    logic               r_mulEq;

    assign in_ready   = ~rst & (r_state == RUN);
    assign w_mulStart = w_accept & (alu_ctrl == OP_MUL);

    mul_iter #(
        .W(D_WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mulStart),
        .i_a       (w_op1),
        .i_b       (w_op2),
        .o_done    (w_mulDone),
        .o_product (w_product)
    );

    // State register: reset always returns to RUN, aborting any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Leave RUN on an accepted multiply and come back in the cycle the multiplier finishes.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RUN:     if (w_mulStart) w_nextState = MUL;
            MUL:     if (w_mulDone)  w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
    end

    // Hold the multiply's destination and compare result until the product is ready for write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mulWe <= 1'b0;
            r_mulRd <= '0;
            r_mulEq <= 1'b0;
        end else if (w_mulStart) begin
            r_mulWe <= reg_write;
            r_mulRd <= rd;
            r_mulEq <= w_eq;
        end
    end

    // Write-back source: the ALU for ordinary ops, the multiplier when it completes.
    always_comb begin
        w_load       = w_accept & ~w_mulStart;
        w_loadWe     = reg_write;
        w_loadRd     = rd;
        w_loadResult = w_aluResult;
        w_loadEq     = w_eq;
        if ((r_state == MUL) && w_mulDone) begin
            w_load       = 1'b1;
            w_loadWe     = r_mulWe;
            w_loadRd     = r_mulRd;
            w_loadResult = w_product;
            w_loadEq     = r_mulEq;
        end
    end
`else
    assign in_ready     = ~rst;
    assign w_load       = w_accept;
    assign w_loadWe     = reg_write;
    assign w_loadRd     = rd;
    assign w_loadResult = w_aluResult;
    assign w_loadEq     = w_eq;
`endif

    // Write-back register: loads on a completed op, otherwise inserts a bubble while holding result/eq.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbValid  <= 1'b0;
            r_wbWe     <= 1'b0;
            r_wbRd     <= '0;
            r_wbResult <= '0;
            r_wbEq     <= 1'b0;
        end else if (w_load) begin
            r_wbValid  <= 1'b1;
            r_wbWe     <= w_loadWe;
            r_wbRd     <= w_loadRd;
            r_wbResult <= w_loadResult;
            r_wbEq     <= w_loadEq;
        end else begin
            r_wbValid <= 1'b0;
            r_wbWe    <= 1'b0;
        end
    end

    // Register file write at the end of the write-back cycle; writes to x0 are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_wbValid && r_wbWe && (r_wbRd != '0)) begin
            r_regs[r_wbRd] <= r_wbResult;
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed testbench for alu_exec_pipe; multiplier scenarios are built when ALU_MUL_EN is defined.
module tb_alu_exec_pipe;
    import alu_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          alu_src;
    logic [3:0]    alu_ctrl;
    logic          reg_write;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [DW-1:0] imm_op;
    logic          out_valid;
    logic [DW-1:0] result;
    logic          eq;
    logic [DW-1:0] a0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_exec_pipe #(
        .A_WIDTH(AW),
        .D_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_src   (alu_src),
        .alu_ctrl  (alu_ctrl),
        .reg_write (reg_write),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm_op    (imm_op),
        .out_valid (out_valid),
        .result    (result),
        .eq        (eq),
        .a0        (a0)
    );

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the rising edge that consumed them.
    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic src, input logic we,
                                 input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                 input logic [AW-1:0] d, input logic [DW-1:0] imm);
        in_valid  = v;
        alu_ctrl  = op;
        alu_src   = src;
        reg_write = we;
        rs1       = a1;
        rs2       = a2;
        rd        = d;
        imm_op    = imm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; alu_ctrl = OP_ADD; alu_src = 1'b0; reg_write = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0; imm_op = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset eq", eq, 0);
        checkOutput("reset a0", a0, 0);
        rst = 1'b0;
        #1;
        checkOutput("ready after reset", in_ready, 1);

        // ADDI x10 = x0 + 5
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 10, 5);
        checkOutput("addi valid", out_valid, 1);
        checkOutput("addi result", result, 5);
        checkOutput("addi eq", eq, 0);
        checkOutput("a0 before write", a0, 0);
        applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, 0);
        checkOutput("bubble valid", out_valid, 0);
        checkOutput("bubble holds result", result, 5);
        checkOutput("a0 after write", a0, 5);

        // Back-to-back dependence through forwarding
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 1, 7);
        checkOutput("x1=7", result, 7);
        applyStimulus(1, OP_ADD, 0, 1, 1, 1, 2, 0);
        checkOutput("x2=x1+x1", result, 14);
        checkOutput("x2 eq", eq, 1);

        // Subtract, shifts and compares
        applyStimulus(1, OP_SUB, 1, 1, 0, 0, 3, 1);
        checkOutput("sub x3", result, 32'hFFFF_FFFF);
        checkOutput("sub eq", eq, 0);
        applyStimulus(1, OP_SRA, 1, 1, 3, 0, 4, 4);
        checkOutput("sra fwd", result, 32'hFFFF_FFFF);
        applyStimulus(1, OP_SRL, 1, 1, 3, 0, 5, 4);
        checkOutput("srl", result, 32'h0FFF_FFFF);
        applyStimulus(1, OP_SLT, 1, 1, 3, 0, 6, 1);
        checkOutput("slt -1<1", result, 1);
        applyStimulus(1, OP_SLTU, 1, 1, 3, 0, 7, 1);
        checkOutput("sltu", result, 0);

        // Equal operands and a write to x0
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 5, 9);
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 6, 9);
        applyStimulus(1, OP_ADD, 0, 1, 5, 6, 0, 0);
        checkOutput("beq result", result, 18);
        checkOutput("beq eq", eq, 1);
        applyStimulus(1, OP_ADD, 0, 1, 0, 0, 8, 0);
        checkOutput("x0 no fwd", result, 0);
        checkOutput("x0 eq", eq, 1);

        // Shift amount masking and logic ops on x1=7
        applyStimulus(1, OP_SLL, 1, 1, 1, 0, 9, 33);
        checkOutput("sll shamt mask", result, 14);
        applyStimulus(1, OP_AND, 1, 0, 1, 0, 0, 32'hC);
        checkOutput("and", result, 4);
        applyStimulus(1, OP_XOR, 1, 0, 1, 0, 0, 5);
        checkOutput("xor", result, 2);
        applyStimulus(1, OP_OR, 1, 0, 1, 0, 0, 8);
        checkOutput("or", result, 15);
        applyStimulus(1, OP_ADD, 0, 1, 10, 2, 11, 0);
        checkOutput("x10+x2", result, 19);
        applyStimulus(1, 4'd15, 0, 1, 1, 2, 12, 0);
        checkOutput("op15 valid", out_valid, 1);
        checkOutput("op15 result", result, 0);
`ifndef ALU_MUL_EN
        applyStimulus(1, OP_MUL, 0, 1, 1, 2, 12, 0);
        checkOutput("op10 valid", out_valid, 1);
        checkOutput("op10 result", result, 0);
        checkOutput("op10 ready", in_ready, 1);
`else
        // Multiply: in_ready drops for D_WIDTH cycles while a held request waits
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 1, 6);
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 2, 7);
        applyStimulus(1, OP_MUL, 0, 1, 1, 2, 3, 0);
        checkOutput("mul start bubble", out_valid, 0);
        checkOutput("mul busy ready", in_ready, 0);
        in_valid = 1'b1; alu_ctrl = OP_ADD; alu_src = 1'b1; reg_write = 1'b1;
        rs1 = 0; rs2 = 0; rd = 12; imm_op = 1;
        for (int k = 1; k <= DW; k++) begin
            @(posedge clk);
            #1;
            if (k < DW) begin
                checkOutput("mul wait ready", in_ready, 0);
                checkOutput("mul wait valid", out_valid, 0);
            end
        end
        checkOutput("mul done valid", out_valid, 1);
        checkOutput("mul result", result, 42);
        checkOutput("mul done ready", in_ready, 1);
        applyStimulus(1, OP_ADD, 1, 1, 0, 0, 12, 1);
        checkOutput("held op result", result, 1);
        checkOutput("held op valid", out_valid, 1);
        applyStimulus(1, OP_ADD, 0, 0, 3, 0, 0, 0);
        checkOutput("x3 after mul", result, 42);

        // Reset ten cycles into a multiply aborts it
        applyStimulus(1, OP_MUL, 0, 1, 1, 1, 3, 0);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mul abort ready", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("mul abort ready after", in_ready, 1);
        begin
            int seen = 0;
            for (int k = 0; k < 40; k++) begin
                applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, 0);
                if (out_valid !== 1'b0) seen++;
            end
            checkOutput("mul abort no valid", seen, 0);
        end
        applyStimulus(1, OP_ADD, 0, 0, 3, 0, 0, 0);
        checkOutput("x3 cleared", result, 0);
`endif

        // Bubble after a completed op
        applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, 0);
        checkOutput("final bubble", out_valid, 0);

        // Mid-run reset clears the register file
        rst = 1'b1;
        applyStimulus(0, OP_ADD, 0, 0, 0, 0, 0, 0);
        checkOutput("rerst ready", in_ready, 0);
        checkOutput("rerst a0", a0, 0);
        checkOutput("rerst result", result, 0);
        rst = 1'b0;
        applyStimulus(1, OP_ADD, 0, 0, 10, 2, 0, 0);
        checkOutput("regs cleared", result, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
